// File: rtl/huff_pkg.sv
// -----------------------------------------------------------------------------
// huff_pkg
// Shared definitions for the Huffman front end (count_frequent, huff_freq_sort,
// tree builder): alphabet size, symbol width, the sorter FSM state encoding and
// the {freq, sym} entry record together with its ordering function.
// -----------------------------------------------------------------------------
package huff_pkg;

  localparam int NSYM   = 16;  // symbols in the alphabet
  localparam int SYM_W  = 4;   // bits per symbol code
  // Widest count the shared entry record can carry. Narrower counts are
  // zero-extended on load, which leaves their relative ordering unchanged.
  localparam int FREQ_W = 16;

  // Sorter FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // freq sits above sym, so the packed value is the sort key {freq, sym}.
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [SYM_W-1:0]  sym;
  } entry_t;

  // True when a must sit after b in ascending {freq, sym} order.
  function automatic logic key_gt(input entry_t a, input entry_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/huff_cmp_swap.sv
// -----------------------------------------------------------------------------
// huff_cmp_swap
// Combinational compare-exchange of two sort entries. The smaller key leaves on
// lo_out, the larger on hi_out; equal keys pass straight through, so ties keep
// their current order.
//   lo_in  / hi_in  : entries at the lower / higher array position
//   lo_out / hi_out : entries to write back to those positions
// -----------------------------------------------------------------------------
module huff_cmp_swap
  import huff_pkg::*;
(
  input  entry_t lo_in,
  input  entry_t hi_in,
  output entry_t lo_out,
  output entry_t hi_out
);

  logic swap;

  assign swap   = key_gt(lo_in, hi_in);
  assign lo_out = swap ? hi_in : lo_in;
  assign hi_out = swap ? lo_in : hi_in;

endmodule

// File: rtl/huff_freq_sort.sv
// -----------------------------------------------------------------------------
// huff_freq_sort
// Captures a 16-entry symbol frequency table, sorts it ascending on
// {freq, sym} with a 16-phase odd-even transposition sort, then streams the
// (symbol, count) pairs to the tree builder over a valid/ready handshake.
//
// Ports
//   CLK           rising-edge clock
//   nRST          asynchronous active-low reset
//   START         one-cycle request to capture and sort (honoured in IDLE only)
//   FREQ_TABLE_IN count of symbol i at [CNT_W*i +: CNT_W]
//   BUSY          high in every state except IDLE
//   OUT_VALID     current (symbol, count) pair is valid
//   OUT_READY     downstream accepts the pair
//   OUT_SYMBOL    symbol code of the current pair
//   OUT_FREQ      count of the current pair
//   OUT_LAST      current pair is the final one (index 15)
//   DONE          one-cycle pulse once the stream has completed
//
// Configuration
//   HUFF_SKIP_ZERO_EN  when defined, entries with a zero count are dropped in
//                      EMIT (one cycle each, OUT_VALID low). Undefined: all 16
//                      entries are emitted.
//
// CNT_W must not exceed huff_pkg::FREQ_W.
// -----------------------------------------------------------------------------
module huff_freq_sort
  import huff_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  START,
  input  logic [NSYM*CNT_W-1:0] FREQ_TABLE_IN,
  output logic                  BUSY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [SYM_W-1:0]      OUT_SYMBOL,
  output logic [CNT_W-1:0]      OUT_FREQ,
  output logic                  OUT_LAST,
  output logic                  DONE
);

  localparam int              NCMP     = NSYM / 2;
  localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(NSYM - 1);

  logic [1:0]       state;
  logic [SYM_W-1:0] phase;   // sort phase 0..15
  logic [SYM_W-1:0] index;   // emit position 0..15
  entry_t           entries [NSYM];
  entry_t           sorted  [NSYM];
  entry_t           cmp_lo_in  [NCMP];
  entry_t           cmp_hi_in  [NCMP];
  entry_t           cmp_lo_out [NCMP];
  entry_t           cmp_hi_out [NCMP];
  logic             odd_phase;
  logic             skip;
  logic             advance;

  assign odd_phase = phase[0];

  // Eight shared comparators. Even phases pair (2p, 2p+1); odd phases pair
  // (2p+1, 2p+2). The last comparator has no odd-phase pair: it is fed
  // (15, 0) and its result is discarded in odd phases.
  for (genvar gp = 0; gp < NCMP; gp++) begin : g_cmp
    assign cmp_lo_in[gp] = odd_phase ? entries[2*gp+1]            : entries[2*gp];
    assign cmp_hi_in[gp] = odd_phase ? entries[(2*gp+2) % NSYM]   : entries[2*gp+1];

    huff_cmp_swap u_cmp_swap (
      .lo_in  (cmp_lo_in[gp]),
      .hi_in  (cmp_hi_in[gp]),
      .lo_out (cmp_lo_out[gp]),
      .hi_out (cmp_hi_out[gp])
    );
  end

  // NOTE: every variable written in always_comb gets a full default first
  // (here the unsorted array), otherwise synthesis infers latches for the
  // entries the current phase leaves untouched.
  always_comb begin
    sorted = entries;
    if (!odd_phase) begin
      for (int p = 0; p < NCMP; p++) begin
        sorted[2*p]   = cmp_lo_out[p];
        sorted[2*p+1] = cmp_hi_out[p];
      end
    end else begin
      for (int p = 0; p < NCMP - 1; p++) begin
        sorted[2*p+1] = cmp_lo_out[p];
        sorted[2*p+2] = cmp_hi_out[p];
      end
    end
  end

`ifdef HUFF_SKIP_ZERO_EN
  assign skip = (state == ST_EMIT) && (entries[index].freq == '0);
`else
  assign skip = 1'b0;
`endif

  assign OUT_VALID  = (state == ST_EMIT) && !skip;
  assign OUT_SYMBOL = entries[index].sym;
  assign OUT_FREQ   = entries[index].freq[CNT_W-1:0];
  assign OUT_LAST   = OUT_VALID && (index == LAST_IDX);
  assign BUSY       = (state != ST_IDLE);
  assign DONE       = (state == ST_FIN);

  // A beat leaves EMIT position `index` either by transfer or by being skipped.
  assign advance = skip || (OUT_VALID && OUT_READY);

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block samples the pre-edge values, exactly as the flops do.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_IDLE;
      phase <= '0;
      index <= '0;
      // NOTE: the entry array is cleared on reset because the output pins are
      // driven straight from it and must read zero after reset; a storage-only
      // array would normally be left unreset.
      for (int i = 0; i < NSYM; i++) begin
        entries[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            for (int i = 0; i < NSYM; i++) begin
              entries[i] <= '{freq: FREQ_W'(FREQ_TABLE_IN[i*CNT_W +: CNT_W]),
                              sym:  SYM_W'(i)};
            end
            phase <= '0;
            state <= ST_SORT;
          end
        end

        ST_SORT: begin
          entries <= sorted;
          phase   <= phase + 1'b1;
          if (phase == LAST_IDX) begin
            index <= '0;
            state <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (advance) begin
            if (index == LAST_IDX) begin
              state <= ST_FIN;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        ST_FIN: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
